// File: rtl/csa_resolve_seq.sv
// Resolves a CSA sum/carry pair into a plain binary value, CHUNK bits per clock,
// with valid/ready handshakes on both sides and one operation in flight at a time.
module csa_resolve_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_sum,
   input  logic [WIDTH-1:0]   in_carry,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH+1:0]   out_data,
   output logic               busy
);

   localparam int RW     = WIDTH + 2;
   localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
   localparam int EXT    = NCHUNK * CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state;
   logic [EXT-1:0]  op_a;
   logic [EXT-1:0]  op_b;
   logic [RW-1:0]   result;
   logic [IDXW-1:0] idx;
   logic            cbit;
   logic [CHUNK:0]  chunk_sum;

   // Operands shift right every BUSY cycle, so the adder always sees the low chunk.
   assign chunk_sum = {1'b0, op_a[CHUNK-1:0]}
                    + {1'b0, op_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cbit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         result <= '0;
         idx    <= '0;
         cbit   <= 1'b0;
      end else if (clear) begin
         state <= S_IDLE;
         idx   <= '0;
         cbit  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_a  <= EXT'(in_sum);
                  op_b  <= EXT'({in_carry, 1'b0});
                  cbit  <= 1'b0;
                  idx   <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Result bits past RW would always be zero, so they are simply not stored.
               for (int b = 0; b < RW; b++) begin
                  if (idx == IDXW'(b / CHUNK))
                     result[b] <= chunk_sum[b % CHUNK];
               end
               cbit <= chunk_sum[CHUNK];
               op_a <= op_a >> CHUNK;
               op_b <= op_b >> CHUNK;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign out_data  = result;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Scoreboard bench for csa_resolve_seq: directed cases at CHUNK=4, 1 and 18,
// backpressure, throughput, clear/reset aborts and a random stream.
module tb_csa_resolve_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear, in_valid, in_ready, out_valid, out_ready, busy;
   logic [15:0] in_sum, in_carry;
   logic [17:0] out_data;

   logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_in_sum, a_in_carry;
   logic [17:0] a_out_data;

   logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [15:0] b_in_sum, b_in_carry;
   logic [17:0] b_out_data;

   int          checks = 0;
   int          errors = 0;
   int          abort_flag = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   csa_resolve_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy));

   csa_resolve_seq #(.WIDTH(16), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_sum(a_in_sum), .in_carry(a_in_carry), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .busy(a_busy));

   csa_resolve_seq #(.WIDTH(16), .CHUNK(18)) dut_c18 (
      .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_sum(b_in_sum), .in_carry(b_in_carry), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .busy(b_busy));

   // Presents one pair, waits for acceptance, then scrambles the inputs.
   task automatic send(input logic [15:0] s, input logic [15:0] c, input logic [17:0] e);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      while (!in_ready && n < 50 && abort_flag == 0) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL send_accept: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sum   = 16'($urandom);
      in_carry = 16'($urandom);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_sum = '0; in_carry = '0;
      a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_sum = '0; a_in_carry = '0;
      b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_sum = '0; b_in_carry = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (out_data !== 18'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 00000", out_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [15:0] ts[4] = '{16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      logic [15:0] tc[4] = '{16'h0001, 16'h0001, 16'h0000, 16'hFFFF};
      logic [17:0] te[4] = '{18'h00101, 18'h10001, 18'h0FFFF, 18'h2FFFD};
      logic [17:0] e;
      int edges;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(ts[i], tc[i], te[i]);
         edges = 0;
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL directed_busy[%0d]: busy=%b in_ready=%b want 1/0", i, busy, in_ready);
         end
         while (!out_valid && edges < 100) begin
            @(negedge clk);
            edges++;
         end
         checks++;
         if (edges !== 5) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d want 5", i, edges); end
         e = exp_q.pop_front();
         checks++;
         if (out_data !== e) begin errors++; $display("[TB] FAIL directed_data[%0d]: got %h want %h", i, out_data, e); end
         @(posedge clk);
         #1;
      end
      checks++;
      if (out_data[17:16] !== 2'b10) begin
         errors++;
         $display("[TB] FAIL directed_top_bits: got %b want 10", out_data[17:16]);
      end
   endtask

   task automatic test_chunk_widths();
      logic [17:0] e;
      int edges;
      @(negedge clk);
      a_in_valid = 1'b1; a_in_sum = 16'hFFFF; a_in_carry = 16'hFFFF;
      checks++;
      if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL c1_ready: got %b want 1", a_in_ready); end
      @(posedge clk);
      #1;
      a_in_valid = 1'b0; a_in_sum = 16'h0; a_in_carry = 16'h0;
      exp_q.push_back(18'h2FFFD);
      edges = 0;
      @(negedge clk);
      while (!a_out_valid && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      checks++;
      if (edges !== 18) begin errors++; $display("[TB] FAIL c1_latency: got %0d want 18", edges); end
      e = exp_q.pop_front();
      checks++;
      if (a_out_data !== e) begin errors++; $display("[TB] FAIL c1_data: got %h want %h", a_out_data, e); end

      @(negedge clk);
      b_in_valid = 1'b1; b_in_sum = 16'hFFFF; b_in_carry = 16'hFFFF;
      checks++;
      if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL c18_ready: got %b want 1", b_in_ready); end
      @(posedge clk);
      #1;
      b_in_valid = 1'b0; b_in_sum = 16'h0; b_in_carry = 16'h0;
      exp_q.push_back(18'h2FFFD);
      edges = 0;
      @(negedge clk);
      while (!b_out_valid && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      checks++;
      if (edges !== 1) begin errors++; $display("[TB] FAIL c18_latency: got %0d want 1", edges); end
      e = exp_q.pop_front();
      checks++;
      if (b_out_data !== e) begin errors++; $display("[TB] FAIL c18_data: got %h want %h", b_out_data, e); end
   endtask

   task automatic test_backpressure();
      logic [17:0] e;
      int n;
      out_ready = 1'b0;
      send(16'h0F0F, 16'h00F0, 18'h010EF);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1; in_sum = 16'h0001; in_carry = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold[%0d]: out_valid=%b out_data=%h in_ready=%b want 1/%h/0",
                     i, out_valid, out_data, in_ready, exp_q[0]);
         end
         @(negedge clk);
      end
      e = exp_q.pop_front();
      exp_q.push_back(18'h00003);
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL release_idle: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
      checks++;
      if (out_data !== e) begin errors++; $display("[TB] FAIL release_hold_data: got %h want %h", out_data, e); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e) begin errors++; $display("[TB] FAIL held_input_data: got %h want %h", out_data, e); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [17:0] e;
      int accepts = 0;
      int hs = 0;
      @(negedge clk);
      in_valid = 1'b1; in_sum = 16'h1111; in_carry = 16'h2222;
      out_ready = 1'b1;
      for (int i = 0; i < 21; i++) begin
         if (in_valid && in_ready) begin
            accepts++;
            exp_q.push_back(18'h05555);
         end
         if (out_valid && out_ready) begin
            hs++;
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", hs, out_data, e); end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (accepts !== 3) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d want 3", accepts); end
      checks++;
      if (hs !== 3) begin errors++; $display("[TB] FAIL b2b_results: got %0d want 3", hs); end
      exp_q.delete();
   endtask

   task automatic test_clear();
      logic [17:0] e;
      int seen = 0;
      int n;
      send(16'hABCD, 16'h1111, 18'h0CDEF);
      @(posedge clk);
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      void'(exp_q.pop_back());
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clear_idle: out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
      end
      checks++;
      if (out_data !== 18'h055EF) begin errors++; $display("[TB] FAIL clear_partial: got %h want 055EF", out_data); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL clear_no_output: got %0d valid cycles want 0", seen); end
      @(negedge clk);
      in_valid = 1'b1; clear = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; clear = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_over_accept: busy=%b want 0", busy); end
      send(16'h1234, 16'h0100, 18'h01434);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e) begin errors++; $display("[TB] FAIL after_clear_data: got %h want %h", out_data, e); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      send(16'h5A5A, 16'h0F0F, 18'h07878);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 18'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: in_ready=%b out_valid=%b busy=%b out_data=%h want 1/0/0/00000",
                  in_ready, out_valid, busy, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL reset_no_output: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_random();
      logic [15:0] s, c;
      logic [17:0] e;
      int got = 0;
      int cyc = 0;
      fork
         begin
            for (int i = 0; i < 1000 && abort_flag == 0; i++) begin
               s = 16'($urandom);
               c = 16'($urandom);
               send(s, c, {2'b00, s} + {1'b0, c, 1'b0});
            end
         end
         begin
            while (got < 1000 && cyc < 30000) begin
               @(negedge clk);
               cyc++;
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  got++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("[TB] FAIL random_extra[%0d]: got %h want no output", got, out_data);
                  end else begin
                     e = exp_q.pop_front();
                     if (out_data !== e) begin
                        errors++;
                        $display("[TB] FAIL random_data[%0d]: got %h want %h", got, out_data, e);
                     end
                  end
               end
            end
            if (got < 1000) abort_flag = 1;
         end
      join
      checks++;
      if (got !== 1000) begin errors++; $display("[TB] FAIL random_count: got %0d want 1000", got); end
      @(negedge clk);
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_chunk_widths();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
